matrix_unpacker: RTL and testbench

Takes a flat 256-bit 4x4 matrix, as produced by the math modules (transpose, etc.), and streams it out one 16-bit element per transfer over a valid/ready handshake. It is the receive-side counterpart of the matrix packing those modules use, for feeding results to 16-bit memory or bus writers. It captures the matrix on an enable pulse and signals completion with a done pulse.

---
 rtl/matrix_pkg.sv | 19 +
 rtl/matrix_elem_sel.sv | 20 ++
 rtl/matrix_unpacker.sv | 119 +++++++++++
 tb/tb_matrix_unpacker.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// matrix_pkg: shared sizes, FSM state encoding and the element offset helper
// for the 4x4 matrix modules. Element [r][c] of a flat matrix sits at bit
// offset r*DIM*DATA_W + c*DATA_W.
package matrix_pkg;

    localparam int DATA_W = 16;
    localparam int DIM    = 4;
    localparam int MAT_W  = DATA_W * DIM * DIM;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    function automatic int unsigned elem_offset(input logic [1:0] r, input logic [1:0] c);
        return (int'(r) * DIM * DATA_W) + (int'(c) * DATA_W);
    endfunction

endpackage

// File: rtl/matrix_elem_sel.sv
// matrix_elem_sel: combinational 16:1 element mux.
// Ports:
//   shadow_i  flat 4x4 matrix (MAT_W bits)
//   row_i     row index
//   col_i     column index
//   elem_o    element [row_i][col_i] (DATA_W bits)
module matrix_elem_sel
    import matrix_pkg::*;
(
    input  logic [MAT_W-1:0]  shadow_i,
    input  logic [1:0]        row_i,
    input  logic [1:0]        col_i,
    output logic [DATA_W-1:0] elem_o
);

    always_comb begin
        elem_o = shadow_i[elem_offset(row_i, col_i) +: DATA_W];
    end

endmodule

// File: rtl/matrix_unpacker.sv
// matrix_unpacker: captures a flat 4x4 matrix on an enable pulse and streams
// it out one element per valid/ready transfer, followed by a one-cycle done.
//
// Build option: define UNPACK_COL_MAJOR_EN to stream in column-major order;
// out_row/out_col always report the source indices of the element.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   enable     load request, sampled only when idle
//   matrix     flat matrix input (MAT_W bits)
//   busy       a matrix is held or being sent
//   out_data   current element
//   out_valid  out_data/out_row/out_col/out_last are valid
//   out_ready  sink accepts the element this cycle
//   out_row    source row of out_data
//   out_col    source column of out_data
//   out_last   current element is the final one of the matrix
//   done       one-cycle pulse after the last transfer
//
// state   | meaning
// --------+----------------------------------------------
// ST_IDLE | waiting for enable, outputs quiet
// ST_SEND | presenting shadow element selected by counter
module matrix_unpacker
    import matrix_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [MAT_W-1:0]  matrix,
    output logic              busy,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [1:0]        out_row,
    output logic [1:0]        out_col,
    output logic              out_last,
    output logic              done
);

    state_t             state_q;
    logic [MAT_W-1:0]   shadow_q;
    logic [3:0]         cnt_q;
    logic [3:0]         cnt_d;
    logic               busy_q;
    logic               valid_q;
    logic               done_q;

    logic [1:0]         row_sel;
    logic [1:0]         col_sel;
    logic [DATA_W-1:0]  elem;

    always_comb begin
        cnt_d = cnt_q + 4'd1;
`ifdef UNPACK_COL_MAJOR_EN
        row_sel = cnt_q[1:0];
        col_sel = cnt_q[3:2];
`else
        row_sel = cnt_q[3:2];
        col_sel = cnt_q[1:0];
`endif
    end

    matrix_elem_sel u_elem_sel (
        .shadow_i (shadow_q),
        .row_i    (row_sel),
        .col_i    (col_sel),
        .elem_o   (elem)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            shadow_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (enable) begin
                        shadow_q <= matrix;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        valid_q  <= 1'b1;
                        state_q  <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (out_ready) begin
                        if (cnt_q == 4'd15) begin
                            cnt_q   <= '0;
                            busy_q  <= 1'b0;
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= ST_IDLE;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Data and indices are forced to zero outside SEND so an idle bus is quiet.
    assign busy      = busy_q;
    assign out_valid = valid_q;
    assign done      = done_q;
    assign out_last  = valid_q && (cnt_q == 4'd15);
    assign out_data  = valid_q ? elem : '0;
    assign out_row   = valid_q ? row_sel : 2'd0;
    assign out_col   = valid_q ? col_sel : 2'd0;

endmodule

// File: tb/tb_matrix_unpacker.sv
module tb_matrix_unpacker;
    import matrix_pkg::*;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              enable = 1'b0;
    logic [MAT_W-1:0]  matrix = '0;
    logic              busy;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [1:0]        out_row;
    logic [1:0]        out_col;
    logic              out_last;
    logic              done;

    always #5 clk = ~clk;

    matrix_unpacker dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .matrix    (matrix),
        .busy      (busy),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_row   (out_row),
        .out_col   (out_col),
        .out_last  (out_last),
        .done      (done)
    );

    typedef struct {
        logic [15:0] d;
        logic [1:0]  r;
        logic [1:0]  c;
        logic        l;
    } exp_t;

    exp_t        sb[$];
    logic        exp_done = 1'b0;
    logic [15:0] cur_m[4][4];
    int          total = 0;
    int          bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [MAT_W-1:0] pack_m();
        logic [MAT_W-1:0] f;
        f = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                f[r*64 + c*16 +: 16] = cur_m[r][c];
        return f;
    endfunction

    // Reference order: k-th element streamed, derived from the stream order rule.
    task automatic push_expected();
        exp_t e;
        int r, c;
        for (int k = 0; k < 16; k++) begin
`ifdef UNPACK_COL_MAJOR_EN
            r = k % 4; c = k / 4;
`else
            r = k / 4; c = k % 4;
`endif
            e.d = cur_m[r][c];
            e.r = 2'(r);
            e.c = 2'(c);
            e.l = (k == 15);
            sb.push_back(e);
        end
    endtask

    // Called at posedge+1 while idle; enable is sampled on the next edge.
    task automatic issue();
        matrix = pack_m();
        enable = 1'b1;
        push_expected();
        @(posedge clk); #1;
        enable = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (n < budget) begin
            @(negedge clk);
            n++;
            if (done) break;
        end
        if (!done) begin
            total++; bad++;
            $display("FAIL wait_done: timeout after %0d cycles", n);
        end
    endtask

    // Monitor: compares every presented element against the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                chk("done_pulse", 32'(done), 32'(exp_done));
                chk("busy_vs_valid", 32'(busy), 32'(out_valid));
                exp_done = 1'b0;
                if (out_valid) begin
                    if (sb.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_elem: got %0h want none", out_data);
                    end else begin
                        e = sb[0];
                        chk("out_data", 32'(out_data), 32'(e.d));
                        chk("out_row", 32'(out_row), 32'(e.r));
                        chk("out_col", 32'(out_col), 32'(e.c));
                        chk("out_last", 32'(out_last), 32'(e.l));
                        if (out_ready) begin
                            void'(sb.pop_front());
                            exp_done = e.l;
                        end
                    end
                end else begin
                    chk("last_idle", 32'(out_last), 32'd0);
                end
            end
        end
    end

    initial begin
        int n, bcnt;
        logic [15:0] base[16];

        base = '{16'd5, 16'd8, 16'd9, 16'd2, 16'd7, 16'd3, 16'd8, 16'd4,
                 16'd6, 16'd5, 16'd4, 16'd3, 16'd8, 16'd5, 16'd7, 16'd6};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_row", 32'(out_row), 32'd0);
        chk("rst_col", 32'(out_col), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;

        // Basic stream
        for (int k = 0; k < 16; k++) cur_m[k/4][k%4] = base[k];
        issue();
        @(negedge clk);
        chk("first_valid_latency", 32'(out_valid), 32'd1);
        bcnt = 0;
        n = 0;
        while (!done && n < 100) begin
            if (busy) bcnt++;
            @(negedge clk);
            n++;
        end
        chk("done_seen", 32'(done), 32'd1);
        chk("busy_cycles", 32'(bcnt), 32'd16);
        @(posedge clk); #1;

        // Backpressure at counter 5
        issue();
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_data", 32'(out_data), 32'd3);
            chk("stall_row", 32'(out_row), 32'd1);
            chk("stall_col", 32'(out_col), 32'd1);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        wait_done(100);
        @(posedge clk); #1;

        // Input isolation: matrix changes and enable pulses during SEND
        issue();
        matrix = {MAT_W{1'b1}};
        repeat (4) @(posedge clk);
        #1;
        enable = 1'b1;
        @(posedge clk); #1;
        enable = 1'b0;
        wait_done(100);
        repeat (3) @(negedge clk);
        chk("no_restart", 32'(out_valid), 32'd0);
        @(posedge clk); #1;

        // Back-to-back: enable during the done cycle
        for (int k = 0; k < 16; k++) cur_m[k/4][k%4] = 16'($urandom);
        issue();
        wait_done(100);
        for (int k = 0; k < 16; k++) cur_m[k/4][k%4] = 16'(k + 1);
        matrix = pack_m();
        enable = 1'b1;
        push_expected();
        @(posedge clk); #1;
        enable = 1'b0;
        @(negedge clk);
        chk("b2b_valid", 32'(out_valid), 32'd1);
        chk("b2b_data", 32'(out_data), 32'd1);
        wait_done(100);
        @(posedge clk); #1;

        // Random matrices with random backpressure
        for (int t = 0; t < 4; t++) begin
            for (int k = 0; k < 16; k++) cur_m[k/4][k%4] = 16'($urandom);
            issue();
            n = 0;
            do begin
                out_ready = 1'($urandom_range(0, 1));
                @(negedge clk);
                n++;
                if (!done) begin
                    @(posedge clk); #1;
                end
            end while (!done && n < 400);
            chk("rand_done", 32'(done), 32'd1);
            out_ready = 1'b1;
            @(posedge clk); #1;
        end

        // Reset abort at counter 7
        for (int k = 0; k < 16; k++) cur_m[k/4][k%4] = base[k];
        issue();
        repeat (7) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("abort_valid", 32'(out_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_data", 32'(out_data), 32'd0);
        sb.delete();
        exp_done = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (5) @(negedge clk);
        chk("abort_no_done_idle", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        issue();
        @(negedge clk);
        chk("restart_row", 32'(out_row), 32'd0);
        chk("restart_col", 32'(out_col), 32'd0);
        chk("restart_data", 32'(out_data), 32'(cur_m[0][0]));
        wait_done(100);

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
